// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and default constants.
//   state_t          - PC/nPC sequencer state (SEQ, DELAY, SQUASH)
//   RESET_PC         - default pc after reset
//   INC_DEFAULT      - default sequential increment
//   TRAP_VEC_DEFAULT - default trap entry address
package cpu_pkg;
   typedef enum logic [1:0] {
      SEQ    = 2'd0,
      DELAY  = 2'd1,
      SQUASH = 2'd2
   } state_t;
   localparam logic [31:0] RESET_PC         = 32'h0;
   localparam logic [31:0] INC_DEFAULT      = 32'h4;
   localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h80;
endpackage

// File: rtl/pc_incrementer.sv
// pc_incrementer: combinational address increment, wraps modulo 2^WIDTH.
//   a (in, WIDTH)  - address to advance
//   y (out, WIDTH) - a + INC
module pc_incrementer #(
   parameter int unsigned       WIDTH = 32,
   parameter logic [WIDTH-1:0]  INC   = WIDTH'(4)
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);
   assign y = a + INC;
endmodule

// File: rtl/pc_npc_unit.sv
// pc_npc_unit: PC/nPC sequencer with one delay slot, annul, stall, trap and eret.
//   clk, reset (async, active-high)
//   stall                       - hold all state
//   br_valid/br_taken/br_annul  - branch at pc resolved this cycle
//   br_target                   - branch target
//   trap, eret                  - trap entry / return
//   pc, npc                     - current and next fetch address
//   epc, enpc                   - pc/npc saved at trap entry
//   slot_valid                  - instruction at pc executes (0 = squashed)
//   in_delay_slot               - pc is the delay slot of a taken branch
//   br_in_slot                  - pulse: branch in a delay slot was ignored
module pc_npc_unit #(
   parameter int unsigned       WIDTH    = 32,
   parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(cpu_pkg::RESET_PC),
   parameter logic [WIDTH-1:0]  INC      = WIDTH'(cpu_pkg::INC_DEFAULT),
   parameter logic [WIDTH-1:0]  TRAP_VEC = WIDTH'(cpu_pkg::TRAP_VEC_DEFAULT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_valid,
   input  logic             br_taken,
   input  logic             br_annul,
   input  logic [WIDTH-1:0] br_target,
   input  logic             trap,
   input  logic             eret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] npc,
   output logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] enpc,
   output logic             slot_valid,
   output logic             in_delay_slot,
   output logic             br_in_slot
);
   import cpu_pkg::*;

   logic [WIDTH-1:0] pc_q, pc_d, npc_q, npc_d, epc_q, epc_d, enpc_q, enpc_d, npc_inc;
   state_t           state_q, state_d;
   logic             br_in_slot_q, br_in_slot_d;

   pc_incrementer #(.WIDTH(WIDTH), .INC(INC)) u_inc (.a(npc_q), .y(npc_inc));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         npc_q        <= RESET_PC + INC;
         epc_q        <= '0;
         enpc_q       <= '0;
         state_q      <= SEQ;
         br_in_slot_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         npc_q        <= npc_d;
         epc_q        <= epc_d;
         enpc_q       <= enpc_d;
         state_q      <= state_d;
         br_in_slot_q <= br_in_slot_d;
      end
   end

   always_comb begin
      pc_d         = pc_q;
      npc_d        = npc_q;
      epc_d        = epc_q;
      enpc_d       = enpc_q;
      state_d      = state_q;
      br_in_slot_d = 1'b0;
      if (trap) begin
         epc_d   = pc_q;
         enpc_d  = npc_q;
         pc_d    = TRAP_VEC;
         npc_d   = TRAP_VEC + INC;
         state_d = SEQ;
      end else if (eret) begin
         pc_d    = epc_q;
         npc_d   = enpc_q;
         state_d = SEQ;
      end else if (!stall) begin
         pc_d    = npc_q;
         npc_d   = npc_inc;
         state_d = SEQ;
         // Only a branch seen in SEQ redirects; in DELAY it is reported, in SQUASH it is dropped.
         if (br_valid && state_q == SEQ) begin
            if (br_taken) begin
               npc_d   = br_target;
               state_d = DELAY;
            end else if (br_annul) begin
               state_d = SQUASH;
            end
         end
         br_in_slot_d = br_valid && state_q == DELAY;
      end
   end

   assign pc            = pc_q;
   assign npc           = npc_q;
   assign epc           = epc_q;
   assign enpc          = enpc_q;
   assign slot_valid    = state_q != SQUASH;
   assign in_delay_slot = state_q == DELAY;
   assign br_in_slot    = br_in_slot_q;
endmodule

// File: tb/tb_pc_npc_unit.sv
// tb_pc_npc_unit: directed self-checking bench for pc_npc_unit (32-bit and 8-bit wrap instances).
module tb_pc_npc_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0, br_valid = 1'b0, br_taken = 1'b0, br_annul = 1'b0;
   logic        trap = 1'b0, eret = 1'b0;
   logic [31:0] br_target = '0;
   logic [31:0] pc, npc, epc, enpc;
   logic        slot_valid, in_delay_slot, br_in_slot;
   logic [7:0]  w_pc, w_npc, w_epc, w_enpc;
   logic        w_sv, w_ids, w_bis;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   pc_npc_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
      .br_annul(br_annul), .br_target(br_target), .trap(trap), .eret(eret),
      .pc(pc), .npc(npc), .epc(epc), .enpc(enpc), .slot_valid(slot_valid),
      .in_delay_slot(in_delay_slot), .br_in_slot(br_in_slot)
   );

   pc_npc_unit #(.WIDTH(8), .RESET_PC(8'hF8), .INC(8'h4), .TRAP_VEC(8'h80)) dut_w (
      .clk(clk), .reset(reset), .stall(1'b0), .br_valid(1'b0), .br_taken(1'b0),
      .br_annul(1'b0), .br_target(8'h0), .trap(1'b0), .eret(1'b0),
      .pc(w_pc), .npc(w_npc), .epc(w_epc), .enpc(w_enpc), .slot_valid(w_sv),
      .in_delay_slot(w_ids), .br_in_slot(w_bis)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      stall = 0; br_valid = 0; br_taken = 0; br_annul = 0; trap = 0; eret = 0; br_target = '0;
   endtask

   task automatic rst_to(input int n);
      clr();
      reset = 1;
      #1;
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #12;
      chk("rst_pc", pc, 32'h0);
      chk("rst_npc", npc, 32'h4);
      chk("rst_epc", epc, 32'h0);
      chk("rst_enpc", enpc, 32'h0);
      chk("rst_sv", {31'b0, slot_valid}, 1);
      chk("rst_ids", {31'b0, in_delay_slot}, 0);
      chk("rst_bis", {31'b0, br_in_slot}, 0);
      chk("w_rst_pc", {24'b0, w_pc}, 32'hF8);
      chk("w_rst_npc", {24'b0, w_npc}, 32'hFC);
      @(negedge clk);
      reset = 0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("seq_pc", pc, 32'(4 * i));
         chk("seq_npc", npc, 32'(4 * i + 4));
         chk("seq_sv", {31'b0, slot_valid}, 1);
         chk("w_pc", {24'b0, w_pc}, {24'b0, 8'(8'hF8 + 8'(4 * i))});
         chk("w_npc", {24'b0, w_npc}, {24'b0, 8'(8'hFC + 8'(4 * i))});
      end

      rst_to(2);
      chk("tk_pc0", pc, 32'h8);
      br_valid = 1; br_taken = 1; br_annul = 1; br_target = 32'h40;
      step();
      clr();
      chk("tk_pc1", pc, 32'hC);
      chk("tk_npc1", npc, 32'h40);
      chk("tk_ids1", {31'b0, in_delay_slot}, 1);
      chk("tk_sv1", {31'b0, slot_valid}, 1);
      step();
      chk("tk_pc2", pc, 32'h40);
      chk("tk_npc2", npc, 32'h44);
      chk("tk_ids2", {31'b0, in_delay_slot}, 0);

      rst_to(2);
      br_valid = 1; br_taken = 0; br_annul = 1; br_target = 32'h40;
      step();
      chk("an_pc", pc, 32'hC);
      chk("an_sv", {31'b0, slot_valid}, 0);
      br_taken = 1;
      step();
      clr();
      chk("sq_pc", pc, 32'h10);
      chk("sq_npc", npc, 32'h14);
      chk("sq_sv", {31'b0, slot_valid}, 1);
      chk("sq_ids", {31'b0, in_delay_slot}, 0);
      chk("sq_bis", {31'b0, br_in_slot}, 0);
      br_valid = 1;
      step();
      clr();
      chk("nt_pc", pc, 32'h14);
      chk("nt_sv", {31'b0, slot_valid}, 1);

      rst_to(5);
      chk("st_pc0", pc, 32'h14);
      stall = 1; br_valid = 1; br_taken = 1; br_target = 32'h40;
      step();
      step();
      chk("st_pc", pc, 32'h14);
      chk("st_npc", npc, 32'h18);
      chk("st_ids", {31'b0, in_delay_slot}, 0);
      br_valid = 0; trap = 1;
      step();
      chk("tr_epc", epc, 32'h14);
      chk("tr_enpc", enpc, 32'h18);
      chk("tr_pc", pc, 32'h80);
      chk("tr_npc", npc, 32'h84);
      trap = 0; eret = 1;
      step();
      chk("er_pc", pc, 32'h14);
      chk("er_npc", npc, 32'h18);
      trap = 1; eret = 1; stall = 0;
      step();
      clr();
      chk("te_pc", pc, 32'h80);
      chk("te_epc", epc, 32'h14);

      rst_to(2);
      br_valid = 1; br_taken = 1; br_target = 32'h40;
      step();
      br_target = 32'h100;
      step();
      clr();
      chk("bs_pc", pc, 32'h40);
      chk("bs_npc", npc, 32'h44);
      chk("bs_bis", {31'b0, br_in_slot}, 1);
      chk("bs_ids", {31'b0, in_delay_slot}, 0);
      step();
      chk("bs_bis2", {31'b0, br_in_slot}, 0);
      chk("bs_pc2", pc, 32'h44);

      rst_to(2);
      br_valid = 1; br_taken = 1; br_target = 32'h40;
      step();
      clr();
      chk("ar_ids0", {31'b0, in_delay_slot}, 1);
      reset = 1;
      #1;
      chk("ar_pc", pc, 32'h0);
      chk("ar_npc", npc, 32'h4);
      chk("ar_ids", {31'b0, in_delay_slot}, 0);
      @(negedge clk);
      reset = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
- Parametrised PC/nPC sequencer for the fetch stage; successor to the fixed-width nPC register and +4 adder pair.
- Holds the PC/nPC pair with delayed-branch semantics: one delay slot, optional annul of untaken branches, stall hold, and trap entry/return with saved PC/nPC.
- Drives the instruction-memory address (pc) and tells decode whether the instruction at pc is a valid slot or a squashed one.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_PC, 0, pc value after reset.
- INC, 4, sequential increment.
- TRAP_VEC, 32'h80, pc value on trap entry.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold pc, npc and state (load enable low).
- br_valid  in  1  instruction at pc is a conditional branch, resolved this cycle.
- br_taken  in  1  branch outcome; qualified by br_valid.
- br_annul  in  1  annul bit of the branch; qualified by br_valid.
- br_target  in  WIDTH  branch target address.
- trap  in  1  take a trap this cycle.
- eret  in  1  return from trap this cycle.
- pc  out  WIDTH  current fetch address.
- npc  out  WIDTH  next fetch address.
- epc  out  WIDTH  pc saved at trap entry.
- enpc  out  WIDTH  npc saved at trap entry.
- slot_valid  out  1  instruction at pc is to be executed (0 means squashed).
- in_delay_slot  out  1  instruction at pc is the delay slot of a taken branch.
- br_in_slot  out  1  one-cycle pulse: a branch arrived in a delay slot and was ignored.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - pc=RESET_PC, npc=RESET_PC+INC, epc=0, enpc=0.
  - state=SEQ, br_in_slot=0.
- FSM states:
  - SEQ: normal.
  - DELAY: pc holds the delay slot of a taken branch.
  - SQUASH: pc holds the annulled slot of an untaken branch.
- State-derived outputs:
  - slot_valid=0 only in SQUASH.
  - in_delay_slot=1 only in DELAY.
- Per-edge priority: trap > eret > stall > branch > sequential.
- trap (overrides stall):
  - epc<=pc, enpc<=npc.
  - pc<=TRAP_VEC, npc<=TRAP_VEC+INC, state<=SEQ.
- eret (ignored if trap is also high; overrides stall):
  - pc<=epc, npc<=enpc, state<=SEQ.
- stall without trap/eret: all registers hold; br_* inputs ignored (the producer must hold them until the stall clears); br_in_slot=0.
- Sequential step (no br_valid, or state≠SEQ): pc<=npc, npc<=npc+INC, state<=SEQ.
- br_valid in SEQ:
  - Taken: pc<=npc, npc<=br_target, state<=DELAY. The annul bit is ignored when taken; the slot always executes.
  - Untaken with br_annul: pc<=npc, npc<=npc+INC, state<=SQUASH.
  - Untaken without annul: sequential step.
- br_valid in DELAY: sequential step, branch ignored, br_in_slot pulses high for one cycle.
- br_valid in SQUASH: ignored silently; the instruction is not executed.
- Arithmetic: all additions are modulo 2^WIDTH, so wrap-around is legal. Example: npc=2^WIDTH-4 gives next npc=0.
- Latency: every update is visible on outputs one clock after the qualifying edge; no combinational path from inputs to pc/npc.
- Reset mid-operation: immediate return to reset values regardless of state or stall.

Decomposition:
- Shared package (cpu_pkg):
  - state enum {SEQ, DELAY, SQUASH}.
  - Default constants RESET_PC, INC_DEFAULT, TRAP_VEC_DEFAULT.
- One sub-module: pc_incrementer (WIDTH, INC), purely combinational, supersedes the fixed +4 adder; instantiated once, on npc.
- Everything else stays in pc_npc_unit.

Test Plan:
- Reset and sequential run: release reset, 3 clocks with no stimulus -> pc 0,4,8,12 and npc 4,8,12,16; slot_valid=1 throughout.
- Taken branch: at pc=8, br_valid=1, br_taken=1, br_target=0x40 -> next cycle pc=12, in_delay_slot=1; following cycle pc=0x40, npc=0x44.
- Annulled untaken branch: at pc=8, br_valid=1, br_taken=0, br_annul=1 -> pc=12 with slot_valid=0; next cycle pc=16, slot_valid=1.
- Stall plus trap: stall=1 for 2 cycles at pc=20 -> pc holds at 20. Then trap=1 with stall still high -> epc=20, enpc=24, pc=0x80, npc=0x84. Then eret=1 -> pc=20, npc=24.
- Branch in delay slot: taken branch to 0x40 at pc=8, then br_valid=1, br_taken=1 at pc=12 -> br_in_slot pulses, pc=0x40. Also async reset asserted mid-DELAY -> pc=0, npc=4 immediately.
- Wrap-around: WIDTH=8, start pc=0xF8 with sequential steps -> pc 0xF8, 0xFC, 0x00, 0x04.
